// File: rtl/packet_deparser.sv
// Rebuilds full packets from the parser's payload stream plus extracted headers:
// header A, header B, then payload, realigned onto W-byte sop/eop/byteen beats.
module packet_deparser #(
    parameter int WIDTH_DATA_BYTES  = 8,
    parameter int WIDTH_HDR_A_BYTES = 6,
    parameter int WIDTH_HDR_B_BYTES = 4
) (
    input  logic                           clk_host,
    input  logic                           rst,
    input  logic                           bus_in_valid,
    input  logic                           bus_in_sop,
    input  logic                           bus_in_eop,
    input  logic [WIDTH_DATA_BYTES-1:0]    bus_in_byteen,
    input  logic [8*WIDTH_DATA_BYTES-1:0]  bus_in_data,
    input  logic [8*WIDTH_HDR_A_BYTES-1:0] headerA,
    input  logic [8*WIDTH_HDR_B_BYTES-1:0] headerB,
    output logic                           bus_in_ready,
    output logic                           bus_out_valid,
    output logic                           bus_out_sop,
    output logic                           bus_out_eop,
    output logic [WIDTH_DATA_BYTES-1:0]    bus_out_byteen,
    output logic [8*WIDTH_DATA_BYTES-1:0]  bus_out_data,
    output logic                           err_proto
);

    localparam int W   = WIDTH_DATA_BYTES;
    localparam int H   = WIDTH_HDR_A_BYTES + WIDTH_HDR_B_BYTES;
    localparam int CAP = H + W;
    localparam int CW  = $clog2(CAP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          sop_pend_q, sop_pend_nxt;
    logic          err_nxt;
    logic [7:0]    fifo_q   [CAP];
    logic [7:0]    fifo_nxt [CAP];

    logic [8*H-1:0] hdr_cat;
    logic [7:0]     inc [CAP];
    logic [7:0]     cat [CAP];
    logic [7:0]     rem [CAP];
    int             n_in, inc_len, cat_len, emit_n, rem_len;
    logic           draining, legal, acc, acc_sop, acc_eop, closing, emit;
    logic           valid_nxt, sop_nxt, eop_nxt;
    logic [W-1:0]   byteen_nxt;
    logic [8*W-1:0] data_nxt;

    assign hdr_cat      = {headerA, headerB};
    assign bus_in_ready = !(state_q == DRAIN && int'(cnt_q) > W);

    always_comb begin
        n_in = 0;
        for (int i = 0; i < W; i++) n_in += int'(bus_in_byteen[i]);

        draining = (state_q == DRAIN);
        unique case (state_q)
            IDLE:    legal = bus_in_sop;
            BODY:    legal = !bus_in_sop;
            default: legal = bus_in_sop;
        endcase
        acc     = bus_in_valid && bus_in_ready && legal;
        acc_sop = acc && bus_in_sop;
        acc_eop = acc && bus_in_eop;
        err_nxt = err_proto || (bus_in_valid && !acc);

        // Incoming bytes this cycle: header bytes (first on wire first) ahead of payload on sop.
        for (int i = 0; i < CAP; i++) inc[i] = 8'h00;
        inc_len = 0;
        if (acc_sop) begin
            for (int i = 0; i < H; i++) inc[i] = hdr_cat[8*(H-1-i) +: 8];
            for (int i = 0; i < W; i++) inc[H+i] = bus_in_data[8*i +: 8];
            inc_len = H + n_in;
        end else if (acc) begin
            for (int i = 0; i < W; i++) inc[i] = bus_in_data[8*i +: 8];
            inc_len = n_in;
        end

        // In DRAIN the stored tail belongs to the old packet; a new sop starts a fresh queue.
        for (int i = 0; i < CAP; i++) begin
            if (draining || i < int'(cnt_q)) cat[i] = fifo_q[i];
            else                             cat[i] = inc[i - int'(cnt_q)];
        end
        cat_len = draining ? int'(cnt_q) : int'(cnt_q) + inc_len;
        closing = draining || acc_eop;

        if (cat_len >= W)  emit_n = W;
        else if (closing)  emit_n = cat_len;
        else               emit_n = 0;
        emit    = (emit_n > 0);
        rem_len = cat_len - emit_n;

        for (int i = 0; i < CAP; i++) begin
            if (i + emit_n < CAP) rem[i] = cat[i + emit_n];
            else                  rem[i] = 8'h00;
        end

        valid_nxt  = emit;
        sop_nxt    = emit && (sop_pend_q || (acc_sop && !draining));
        eop_nxt    = emit && closing && (cat_len <= W);
        byteen_nxt = '0;
        data_nxt   = '0;
        for (int i = 0; i < W; i++) begin
            if (i < emit_n) begin
                byteen_nxt[i]      = 1'b1;
                data_nxt[8*i +: 8] = cat[i];
            end
        end

        fifo_nxt     = rem;
        cnt_nxt      = CW'(rem_len);
        state_nxt    = state_q;
        sop_pend_nxt = emit ? 1'b0 : (sop_pend_q || acc_sop);
        if (draining) begin
            sop_pend_nxt = acc_sop;
            if (rem_len == 0) begin
                fifo_nxt = inc;
                cnt_nxt  = CW'(inc_len);
                if (acc_sop) state_nxt = acc_eop ? DRAIN : BODY;
                else         state_nxt = IDLE;
            end
        end else if (acc_eop) begin
            state_nxt = (rem_len > 0) ? DRAIN : IDLE;
        end else if (acc_sop) begin
            state_nxt = BODY;
        end
    end

    always_ff @(posedge clk_host) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sop_pend_q     <= 1'b0;
            err_proto      <= 1'b0;
            bus_out_valid  <= 1'b0;
            bus_out_sop    <= 1'b0;
            bus_out_eop    <= 1'b0;
            bus_out_byteen <= '0;
            bus_out_data   <= '0;
        end else begin
            state_q        <= state_nxt;
            cnt_q          <= cnt_nxt;
            sop_pend_q     <= sop_pend_nxt;
            err_proto      <= err_nxt;
            bus_out_valid  <= valid_nxt;
            bus_out_sop    <= sop_nxt;
            bus_out_eop    <= eop_nxt;
            bus_out_byteen <= byteen_nxt;
            bus_out_data   <= data_nxt;
        end
    end

    // NOTE: byte storage has no reset; cnt_q alone defines which bytes are live.
    always_ff @(posedge clk_host) begin
        fifo_q <= fifo_nxt;
    end

endmodule

// File: tb/tb_packet_deparser.sv
// Directed bench for packet_deparser: expected beats go into a queue at stimulus
// time and a negedge monitor pops and compares every beat the DUT presents.
module tb_packet_deparser;

    localparam int W  = 8;
    localparam int HA = 6;
    localparam int HB = 4;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [W-1:0] be;
        logic [8*W-1:0] data;
    } beat_t;

    logic            clk_host = 1'b0;
    logic            rst = 1'b1;
    logic            bus_in_valid = 1'b0, bus_in_sop = 1'b0, bus_in_eop = 1'b0;
    logic [W-1:0]    bus_in_byteen = '0;
    logic [8*W-1:0]  bus_in_data = '0;
    logic [8*HA-1:0] headerA = '0;
    logic [8*HB-1:0] headerB = '0;
    logic            bus_in_ready, bus_out_valid, bus_out_sop, bus_out_eop, err_proto;
    logic [W-1:0]    bus_out_byteen;
    logic [8*W-1:0]  bus_out_data;

    packet_deparser #(
        .WIDTH_DATA_BYTES(W), .WIDTH_HDR_A_BYTES(HA), .WIDTH_HDR_B_BYTES(HB)
    ) dut (
        .clk_host(clk_host), .rst(rst),
        .bus_in_valid(bus_in_valid), .bus_in_sop(bus_in_sop), .bus_in_eop(bus_in_eop),
        .bus_in_byteen(bus_in_byteen), .bus_in_data(bus_in_data),
        .headerA(headerA), .headerB(headerB),
        .bus_in_ready(bus_in_ready),
        .bus_out_valid(bus_out_valid), .bus_out_sop(bus_out_sop), .bus_out_eop(bus_out_eop),
        .bus_out_byteen(bus_out_byteen), .bus_out_data(bus_out_data),
        .err_proto(err_proto)
    );

    always #5 clk_host = ~clk_host;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_host) begin
        if (bus_out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %h byteen %h, expected no beat",
                         bus_out_data, bus_out_byteen);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_beat", 80'({bus_out_sop, bus_out_eop, bus_out_byteen, bus_out_data}),
                      80'(mon_exp));
            end
        end
    end

    function automatic beat_t mk_beat(input logic sop, input logic eop,
                                      input logic [W-1:0] be, input logic [8*W-1:0] data);
        beat_t b;
        b.sop = sop; b.eop = eop; b.be = be; b.data = data;
        return b;
    endfunction

    // Reference: serialise header A, header B, payload, then cut into W-byte beats.
    task automatic push_packet(input logic [8*HA-1:0] ha, input logic [8*HB-1:0] hb,
                               input int plen, input logic [7:0] pstart);
        logic [7:0] bytes[$];
        beat_t      e;
        for (int i = 0; i < HA; i++) bytes.push_back(ha[8*(HA-1-i) +: 8]);
        for (int i = 0; i < HB; i++) bytes.push_back(hb[8*(HB-1-i) +: 8]);
        for (int k = 0; k < plen; k++) bytes.push_back(8'(int'(pstart) + k));
        for (int b = 0; b < bytes.size(); b += W) begin
            e     = '0;
            e.sop = (b == 0);
            e.eop = (b + W >= bytes.size());
            for (int j = 0; j < W; j++) begin
                if (b + j < bytes.size()) begin
                    e.be[j]          = 1'b1;
                    e.data[8*j +: 8] = bytes[b + j];
                end
            end
            exp_q.push_back(e);
        end
    endtask

    // Called #1 after a rising edge; waits (bounded) for ready, then holds the beat for one edge.
    task automatic drive_beat(input logic sop, input logic eop, input int n, input logic [7:0] start);
        int waitc = 0;
        while (!bus_in_ready && waitc < 20) begin
            @(posedge clk_host); #1;
            waitc++;
        end
        if (waitc == 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 for 20 cycles, expected 1");
        end
        bus_in_valid = 1'b1;
        bus_in_sop   = sop;
        bus_in_eop   = eop;
        for (int j = 0; j < W; j++) begin
            bus_in_byteen[j]        = (j < n);
            bus_in_data[8*j +: 8]   = (j < n) ? 8'(int'(start) + j) : 8'hEE;
        end
        @(posedge clk_host); #1;
        bus_in_valid = 1'b0;
        bus_in_sop   = 1'b0;
        bus_in_eop   = 1'b0;
    endtask

    task automatic send_packet(input logic [8*HA-1:0] ha, input logic [8*HB-1:0] hb,
                               input int plen, input logic [7:0] pstart, input bit gap);
        int nb = (plen + W - 1) / W;
        int vcnt = 0;
        push_packet(ha, hb, plen, pstart);
        headerA = ha;
        headerB = hb;
        for (int b = 0; b < nb; b++) begin
            drive_beat(b == 0, b == nb - 1, (plen - b*W > W) ? W : plen - b*W, 8'(int'(pstart) + b*W));
            headerA = ~ha;
            headerB = ~hb;
            if (gap && b == 0) begin
                repeat (3) begin
                    @(posedge clk_host); #1;
                    vcnt += int'(bus_out_valid);
                end
                check("gap_valid_cycles", 80'(vcnt), 80'(1));
            end
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk_host); #1;
            c++;
        end
        check("drain_queue_empty", 80'(exp_q.size()), 80'(0));
        exp_q.delete();
        repeat (2) @(posedge clk_host);
        #1;
    endtask

    task automatic short_beat_literal();
        exp_q.push_back(mk_beat(1'b1, 1'b0, 8'hFF, 64'hB1B0_A5A4_A3A2_A1A0));
        exp_q.push_back(mk_beat(1'b0, 1'b1, 8'hFF, 64'h0504_0302_0100_B3B2));
        headerA = 48'hA0A1_A2A3_A4A5;
        headerB = 32'hB0B1_B2B3;
        drive_beat(1'b1, 1'b1, 6, 8'h00);
        check("short_ready_t1", 80'(bus_in_ready), 80'(1));
        @(posedge clk_host); #1;
        check("short_ready_t2", 80'(bus_in_ready), 80'(1));
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk_host);
        #1;
        check("rst_valid",  80'(bus_out_valid), 80'(0));
        check("rst_sopeop", 80'({bus_out_sop, bus_out_eop}), 80'(0));
        check("rst_byteen", 80'(bus_out_byteen), 80'(0));
        check("rst_data",   80'(bus_out_data), 80'(0));
        check("rst_err",    80'(err_proto), 80'(0));
        check("rst_ready",  80'(bus_in_ready), 80'(1));
        rst = 1'b0;
        @(posedge clk_host); #1;

        short_beat_literal();

        // Single full beat: 18 bytes -> 8, 8, 2 with ready low only in the first output cycle.
        push_packet(48'h1112_1314_1516, 32'h2122_2324, 8, 8'h40);
        headerA = 48'h1112_1314_1516;
        headerB = 32'h2122_2324;
        drive_beat(1'b1, 1'b1, 8, 8'h40);
        check("full_ready_t1", 80'(bus_in_ready), 80'(0));
        @(posedge clk_host); #1;
        check("full_ready_t2", 80'(bus_in_ready), 80'(1));
        wait_drain();

        // Three-beat packet followed by a sop held off until the first eop is emitted.
        send_packet(48'h3132_3334_3536, 32'h4142_4344, 24, 8'h80, 1'b0);
        send_packet(48'h5152_5354_5556, 32'h6162_6364, 6, 8'hC0, 1'b0);
        check("b2b_eop_on_accept", 80'({bus_out_valid, bus_out_eop}), 80'(2'b11));
        @(posedge clk_host); #1;
        check("b2b_sop_next", 80'({bus_out_valid, bus_out_sop}), 80'(2'b11));
        wait_drain();

        // Gap of three idle cycles after the first body beat.
        send_packet(48'h7172_7374_7576, 32'h8182_8384, 24, 8'h10, 1'b1);
        wait_drain();
        check("gap_err", 80'(err_proto), 80'(0));

        // Non-sop beat in IDLE is dropped and flagged.
        bus_in_valid  = 1'b1;
        bus_in_sop    = 1'b0;
        bus_in_eop    = 1'b1;
        bus_in_byteen = 8'hFF;
        bus_in_data   = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk_host); #1;
        bus_in_valid = 1'b0;
        bus_in_eop   = 1'b0;
        repeat (3) @(posedge clk_host);
        #1;
        check("idle_nonsop_err", 80'(err_proto), 80'(1));
        send_packet(48'h9192_9394_9596, 32'hA1A2_A3A4, 5, 8'h20, 1'b0);
        wait_drain();

        // Beat driven while ready is low is dropped; the open packet is unaffected.
        send_packet(48'hC1C2_C3C4_C5C6, 32'hD1D2_D3D4, 8, 8'h50, 1'b0);
        check("viol_ready_low", 80'(bus_in_ready), 80'(0));
        bus_in_valid  = 1'b1;
        bus_in_sop    = 1'b1;
        bus_in_eop    = 1'b1;
        bus_in_byteen = 8'hFF;
        @(posedge clk_host); #1;
        bus_in_valid = 1'b0;
        bus_in_sop   = 1'b0;
        bus_in_eop   = 1'b0;
        wait_drain();
        check("viol_err_sticky", 80'(err_proto), 80'(1));

        // Reset while in BODY: the partial packet's first beat is out, nothing more follows.
        exp_q.push_back(mk_beat(1'b1, 1'b0, 8'hFF, 64'hB1B0_A5A4_A3A2_A1A0));
        headerA = 48'hA0A1_A2A3_A4A5;
        headerB = 32'hB0B1_B2B3;
        drive_beat(1'b1, 1'b0, 8, 8'h60);
        rst = 1'b1;
        @(posedge clk_host); #1;
        check("midrst_outputs", 80'({bus_out_valid, bus_out_sop, bus_out_eop, bus_out_byteen, bus_out_data}), 80'(0));
        check("midrst_ready", 80'(bus_in_ready), 80'(1));
        check("midrst_err", 80'(err_proto), 80'(0));
        rst = 1'b0;
        repeat (4) @(posedge clk_host);
        #1;
        check("midrst_no_tail", 80'(exp_q.size()), 80'(0));
        exp_q.delete();

        short_beat_literal();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
